// File: rtl/punc_pkg.sv
// Shared definitions for the PUNC instruction fetch path: fetch state
// encoding, address width and the default reset PC.
package punc_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = DATA_W;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = '0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

endpackage

// File: rtl/punc_fetch.sv
// PUNC instruction fetch unit: PC register, IR register and IDLE/WAIT/VALID FSM.
// Optional WAIT timeout with fetch_err pulse is enabled by PUNC_FETCH_TIMEOUT_EN.
module punc_fetch
  import punc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = DATA_W,
  parameter logic [DATA_WIDTH-1:0] RESET_PC       = RESET_PC_DEF,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic                  pc_ld,
  input  logic [DATA_WIDTH-1:0] pc_ld_val,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] ir_out,
  output logic                  ir_valid,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  busy,
  output logic                  fetch_err
);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  flush_q, flush_d;
`ifdef PUNC_FETCH_TIMEOUT_EN
  logic [15:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flush_d = flush_q;
`ifdef PUNC_FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pc_ld) pc_d = pc_ld_val;
        if (fetch_req) begin
          state_d = ST_WAIT;
`ifdef PUNC_FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        // A redirect while the read is outstanding discards that read's data.
        if (pc_ld) begin
          pc_d    = pc_ld_val;
          flush_d = 1'b1;
        end
        if (mem_ack) begin
          flush_d = 1'b0;
          if (pc_ld || flush_q) begin
            state_d = ST_IDLE;
          end else begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + DATA_WIDTH'(1);
            state_d = ST_VALID;
          end
        end
`ifdef PUNC_FETCH_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_VALID: begin
        if (pc_ld) pc_d = pc_ld_val;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flush_q <= flush_d;
    end
  end

`ifdef PUNC_FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign fetch_err      = 1'b0;
`endif

  // Memory-side outputs come only from flops, never from inputs.
  assign mem_req  = (state_q == ST_WAIT);
  assign mem_addr = pc_q;
  assign ir_out   = ir_q;
  assign ir_valid = (state_q == ST_VALID);
  assign pc_out   = pc_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_punc_fetch.sv
// Self-checking bench for punc_fetch: directed scenarios plus randomized
// fetch/redirect transactions checked against a transaction-level PC/IR model.
module tb_punc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic        pc_ld;
  logic [15:0] pc_ld_val;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic [15:0] pc_out;
  logic        busy;
  logic        fetch_err;

  int vectors = 0;
  int errors  = 0;

  // Transaction-level reference: architectural PC and last fetched instruction.
  logic [15:0] pc_m;
  logic [15:0] ir_m;

  punc_fetch #(
    .DATA_WIDTH     (16),
    .RESET_PC       (16'h0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .pc_ld     (pc_ld),
    .pc_ld_val (pc_ld_val),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .pc_out    (pc_out),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    pc_m = 16'h0000;
    ir_m = 16'h0000;
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_ld = 1'b1;
    pc_ld_val = v;
    step();
    pc_ld = 1'b0;
    pc_m = v;
    check("ld_pc", pc_out, pc_m);
  endtask

  // Successful fetch: ack after 'delay' extra WAIT cycles.
  task automatic fetch(input logic [15:0] data, input int delay);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("f_mem_req", mem_req, 1'b1);
    check("f_addr", mem_addr, pc_m);
    check("f_busy", busy, 1'b1);
    for (int i = 0; i < delay; i++) begin
      step();
      check("f_wait_req", mem_req, 1'b1);
      check("f_wait_irv", ir_valid, 1'b0);
    end
    mem_ack = 1'b1;
    mem_rdata = data;
    step();
    mem_ack = 1'b0;
    mem_rdata = $urandom_range(0, 65535);
    pc_m = pc_m + 16'd1;
    ir_m = data;
    check("f_irv", ir_valid, 1'b1);
    check("f_ir", ir_out, ir_m);
    check("f_pc", pc_out, pc_m);
    check("f_req_off", mem_req, 1'b0);
    step();
    check("f_irv_pulse", ir_valid, 1'b0);
    check("f_idle", busy, 1'b0);
    check("f_ir_hold", ir_out, ir_m);
  endtask

  // Fetch redirected one cycle into WAIT; ack after 'delay' more cycles is discarded.
  task automatic flushed_fetch(input logic [15:0] target, input int delay);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("x_addr", mem_addr, pc_m);
    pc_ld = 1'b1;
    pc_ld_val = target;
    step();
    pc_ld = 1'b0;
    pc_m = target;
    check("x_pc", pc_out, pc_m);
    check("x_req_held", mem_req, 1'b1);
    for (int i = 0; i < delay; i++) begin
      step();
      check("x_wait_req", mem_req, 1'b1);
    end
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    check("x_irv", ir_valid, 1'b0);
    check("x_idle", busy, 1'b0);
    check("x_ir", ir_out, ir_m);
    check("x_pc_after", pc_out, pc_m);
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0;
    pc_ld = 1'b0;
    pc_ld_val = '0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    do_reset();

    check("rst_pc", pc_out, 16'h0000);
    check("rst_ir", ir_out, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_irv", ir_valid, 1'b0);
    check("rst_err", fetch_err, 1'b0);

    // Minimum-latency fetch from reset PC.
    fetch(16'h1234, 0);

    // PC wrap from FFFF.
    load_pc(16'hFFFF);
    fetch(16'h5020, 0);
    check("wrap_pc", pc_out, 16'h0000);

    // Load + fetch_req together in IDLE: fetch uses the new PC.
    pc_ld = 1'b1;
    pc_ld_val = 16'h0200;
    fetch_req = 1'b1;
    step();
    pc_ld = 1'b0;
    fetch_req = 1'b0;
    pc_m = 16'h0200;
    check("ldf_addr", mem_addr, 16'h0200);
    mem_ack = 1'b1;
    mem_rdata = 16'hA5A5;
    step();
    mem_ack = 1'b0;
    pc_m = 16'h0201;
    ir_m = 16'hA5A5;
    check("ldf_ir", ir_out, ir_m);
    check("ldf_pc", pc_out, pc_m);
    // fetch_req held through VALID must be ignored there.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("valid_ign_busy", busy, 1'b0);
    step();

    // Redirect in WAIT, ack 3 cycles later, then fetch from the new PC.
    flushed_fetch(16'h3000, 2);
    fetch(16'h7777, 0);
    check("after_flush_pc", pc_out, 16'h3001);

    // Load and ack in the same WAIT cycle: load wins.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    pc_ld = 1'b1;
    pc_ld_val = 16'h4000;
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    step();
    pc_ld = 1'b0;
    mem_ack = 1'b0;
    pc_m = 16'h4000;
    check("race_pc", pc_out, 16'h4000);
    check("race_irv", ir_valid, 1'b0);
    check("race_idle", busy, 1'b0);
    check("race_ir", ir_out, ir_m);

`ifdef PUNC_FETCH_TIMEOUT_EN
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("to_err_early", fetch_err, 1'b0);
      check("to_busy", busy, 1'b1);
      step();
    end
    check("to_busy_last", busy, 1'b1);
    step();
    check("to_err", fetch_err, 1'b1);
    check("to_idle", busy, 1'b0);
    check("to_pc", pc_out, pc_m);
    check("to_ir", ir_out, ir_m);
    step();
    check("to_err_pulse", fetch_err, 1'b0);
`else
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      check("hold_req", mem_req, 1'b1);
      step();
    end
    check("hold_err", fetch_err, 1'b0);
    check("hold_pc", pc_out, pc_m);
`endif

    // Reset mid-WAIT, then a stray ack while IDLE.
    load_pc(16'h1111);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("rw_req", mem_req, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hCAFE;
    check("rw_pc_rst", pc_out, 16'h0000);
    step();
    mem_ack = 1'b0;
    pc_m = 16'h0000;
    ir_m = 16'h0000;
    check("rw_pc", pc_out, pc_m);
    check("rw_ir", ir_out, ir_m);
    check("rw_irv", ir_valid, 1'b0);
    check("rw_busy", busy, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) load_pc(16'($urandom));
      if ($urandom_range(0, 3) == 0)
        flushed_fetch(16'($urandom), int'($urandom_range(0, 2)));
      else
        fetch(16'($urandom), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) step();
      check("rnd_idle_pc", pc_out, pc_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/punc_fetch.md
PUNC_FETCH -- requirements
Module: punc_fetch

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 16, instruction and address width.
- RESET_PC, 16'h0000, PC value after reset.
- TIMEOUT_CYCLES, 16, WAIT cycles before abort (used only when PUNC_FETCH_TIMEOUT_EN is defined).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high; clock clk.
- fetch_req  in  1  control FSM requests the next instruction.
- pc_ld  in  1  load PC (branch, jump, JSR).
- pc_ld_val  in  16  new PC value.
- mem_req  out  1  memory read request.
- mem_addr  out  16  memory read address.
- mem_rdata  in  16  memory read data, valid with mem_ack.
- mem_ack  in  1  memory read complete.
- ir_out  out  16  instruction register, feeds the control unit's IR_data.
- ir_valid  out  1  one-cycle pulse: new instruction in ir_out.
- pc_out  out  16  current PC.
- busy  out  1  high when state is not IDLE.
- fetch_err  out  1  one-cycle timeout pulse.

Function
REQ-003 The FSM SHALL have three states: IDLE, WAIT and VALID.
REQ-004 IDLE with fetch_req=1 SHALL go to WAIT next cycle; fetch_req SHALL be ignored in WAIT and VALID.
REQ-005 In WAIT, mem_req SHALL be 1 and mem_addr SHALL equal the PC register; both SHALL be registered or derived from state only, with no combinational path from inputs.
REQ-006 In WAIT with mem_ack=1 and pc_ld=0, the block SHALL, on that edge, load ir_out<=mem_rdata, set PC<=PC+1 (mod 2^16, FFFF wraps to 0000) and move to VALID.
REQ-007 VALID SHALL assert ir_valid for exactly one cycle, then return to IDLE.
REQ-008 Minimum latency SHALL be: fetch_req at cycle 0, mem_req at cycle 1, ack at cycle 1, ir_valid at cycle 2.
REQ-009 ir_out SHALL hold its value until the next successful fetch.
REQ-010 pc_ld in IDLE or VALID SHALL set PC<=pc_ld_val next edge.
REQ-011 pc_ld together with fetch_req in IDLE SHALL load the PC and enter WAIT, so the fetch uses pc_ld_val.
REQ-012 pc_ld in WAIT SHALL load the PC and set a flush flag. The outstanding read SHALL stay requested until mem_ack. On that ack, ir_out and the PC SHALL NOT be updated, ir_valid SHALL NOT assert, the flag SHALL clear, and the state SHALL go to IDLE.
REQ-013 pc_ld and mem_ack in the same WAIT cycle SHALL make the load win: PC=pc_ld_val, ir_out unchanged, no ir_valid, next state IDLE.
REQ-014 A later pc_ld SHALL override an earlier one.
REQ-015 busy SHALL be 1 in WAIT and VALID.

Reset
REQ-016 rst SHALL set state=IDLE, PC=RESET_PC, ir_out=16'h0000, ir_valid=0, mem_req=0, fetch_err=0, flush flag=0 and timeout counter=0.
REQ-017 rst SHALL abort any fetch in flight; an ack arriving during or after rst while in IDLE SHALL be ignored.

Configuration
REQ-018 With PUNC_FETCH_TIMEOUT_EN defined:
- A counter SHALL count WAIT cycles.
- If TIMEOUT_CYCLES WAIT cycles pass with no ack, the FSM SHALL go to IDLE, pulse fetch_err for one cycle and leave PC and ir_out unchanged (a pending flush load is kept).
- The counter SHALL clear on entering WAIT.
REQ-019 Without PUNC_FETCH_TIMEOUT_EN, fetch_err SHALL be tied 0, no counter logic SHALL exist, and WAIT SHALL last indefinitely.

Structure
REQ-020 The shared package punc_pkg SHALL hold the fetch state encoding (2-bit), DATA_WIDTH-derived address width, and RESET_PC default.
REQ-021 No sub-module SHALL be used; the FSM, PC incrementer and timeout counter SHALL be inline.

Verification
REQ-022 The bench SHALL cover these scenarios (stimulus -> required response):
- Reset, fetch_req, ack in first WAIT cycle, mem_rdata=16'h1234 -> mem_addr=0000, ir_out=1234, ir_valid at cycle 2, pc_out=0001.
- pc_ld_val=16'hFFFF, fetch, ack with 16'h5020 -> ir_out=5020, pc_out=0000.
- pc_ld=3000 in WAIT, ack 3 cycles later -> ir_out unchanged, no ir_valid, pc_out=3000, then next fetch addr=3000.
- pc_ld=4000 and mem_ack same cycle -> pc_out=4000, no ir_valid, state IDLE.
- Macro on, TIMEOUT_CYCLES=4, no ack -> fetch_err pulse after 4 WAIT cycles, pc_out unchanged, busy=0; macro off -> mem_req held for 100 cycles.
- rst asserted mid-WAIT, ack next cycle -> pc_out=RESET_PC, ir_out=0000, no ir_valid.
